sensor_cmd_tx: RTL

//  UART 8N1 transmitter that sends register-write command packets to the wireless IMU.

---
 rtl/sensor_pkg.sv | 40 ++++
 rtl/sensor_cmd_tx_if.sv | 10 +
 rtl/sensor_cmd_tx_uart_tx_byte.sv | 88 ++++++++
 rtl/sensor_cmd_tx.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared constants and types for the sensor command path.
package sensor_pkg;

    localparam logic [7:0]  SENSOR_HDR0       = 8'hFF;
    localparam logic [7:0]  SENSOR_HDR1       = 8'hAA;
    localparam logic [7:0]  SENSOR_REG_UNLOCK = 8'h69;
    localparam logic [15:0] SENSOR_UNLOCK_KEY = 16'hB588;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } sensor_cmd_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PKT_IDLE,
        PKT_SEND,
        PKT_GAP
    } pkt_state_e;

    // Byte idx of a 5-byte packet: FF AA reg dataL dataH.
    function automatic logic [7:0] sensor_pkt_byte(input logic [3:0] idx, input sensor_cmd_t c);
        logic [7:0] b;
        case (idx)
            4'd0:    b = SENSOR_HDR0;
            4'd1:    b = SENSOR_HDR1;
            4'd2:    b = c.addr;
            4'd3:    b = c.data[7:0];
            default: b = c.data[15:8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sensor_cmd_tx_if.sv
// Command request channel into sensor_cmd_tx.
interface sensor_cmd_tx_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_reg;
    logic [15:0] cmd_data;

    modport master (output cmd_valid, output cmd_reg, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_reg, input cmd_data, output cmd_ready);
endinterface

// File: rtl/sensor_cmd_tx_uart_tx_byte.sv
// 8N1 byte serializer. ready_o is also high on the final stop-bit cycle so the
// next byte can follow with no idle time.
module uart_tx_byte
    import sensor_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       ready_o,
    output logic       txd_o
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LOAD = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_end;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= TX_IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        txd_o    = 1'b1;
        bit_end  = (timer_q == '0);
        ready_o  = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);

        if (state_q != TX_IDLE) begin
            timer_d = bit_end ? T_LOAD : timer_q - TW'(1);
        end

        case (state_q)
            TX_IDLE: txd_o = 1'b1;
            TX_START: begin
                txd_o = 1'b0;
                if (bit_end) begin
                    state_d  = TX_DATA;
                    bitcnt_d = '0;
                end
            end
            TX_DATA: begin
                txd_o = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                txd_o = 1'b1;
                if (bit_end) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (start_i && ready_o) begin
            state_d = TX_START;
            timer_d = T_LOAD;
            shift_d = byte_i;
        end
    end

endmodule

// File: rtl/sensor_cmd_tx.sv
// Sensor register-write command transmitter: FF AA <reg> <dataL> <dataH> over 8N1.
// SENSOR_CMD_UNLOCK_EN: precede each command with the unlock packet and its own gap.
module sensor_cmd_tx
    import sensor_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 11_059_200,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned GAP_BITS = 10
) (
    input  logic          clk_uart,
    input  logic          rst,
    sensor_cmd_tx_if.slave cmd,
    output logic          txd,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned GAP_CYC      = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned GW           = $clog2(GAP_CYC);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYC - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_chk
        $error("sensor_cmd_tx: CLKS_PER_BIT must be at least 2");
    end
    if (GAP_BITS < 1) begin : g_gap_chk
        $error("sensor_cmd_tx: GAP_BITS must be at least 1");
    end

`ifdef SENSOR_CMD_UNLOCK_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd4;
`endif

    pkt_state_e    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    sensor_cmd_t   cmd_q, cmd_d;

    logic          ser_start;
    logic          ser_ready;
    logic [7:0]    ser_byte;
    logic [3:0]    next_idx;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk_i  (clk_uart),
        .rst_i  (rst),
        .start_i(ser_start),
        .byte_i (ser_byte),
        .ready_o(ser_ready),
        .txd_o  (txd)
    );

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            state_q <= PKT_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        next_idx = (state_q == PKT_IDLE) ? 4'd0 : idx_q + 4'd1;
`ifdef SENSOR_CMD_UNLOCK_EN
        if (next_idx >= 4'd5) begin
            ser_byte = sensor_pkt_byte(next_idx - 4'd5, cmd_q);
        end else begin
            ser_byte = sensor_pkt_byte(next_idx, '{addr: SENSOR_REG_UNLOCK, data: SENSOR_UNLOCK_KEY});
        end
`else
        ser_byte = sensor_pkt_byte(next_idx, cmd_q);
`endif
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        cmd_d         = cmd_q;
        ser_start     = 1'b0;
        done          = 1'b0;
        busy          = (state_q != PKT_IDLE);
        cmd.cmd_ready = (state_q == PKT_IDLE) && !rst;

        case (state_q)
            PKT_IDLE: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    cmd_d     = '{addr: cmd.cmd_reg, data: cmd.cmd_data};
                    idx_d     = '0;
                    ser_start = 1'b1;
                    state_d   = PKT_SEND;
                end
            end
            // In SEND the serializer is never idle, so ready means the final stop-bit cycle.
            PKT_SEND: begin
                if (ser_ready) begin
                    if (idx_q == 4'd4 || idx_q == 4'd9) begin
                        gap_d   = GAP_LOAD;
                        state_d = PKT_GAP;
                    end else begin
                        ser_start = 1'b1;
                        idx_d     = next_idx;
                    end
                end
            end
            PKT_GAP: begin
                if (gap_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        done    = 1'b1;
                        state_d = PKT_IDLE;
                    end else begin
                        ser_start = 1'b1;
                        idx_d     = next_idx;
                        state_d   = PKT_SEND;
                    end
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = PKT_IDLE;
        endcase
    end

endmodule
